sl_fifo_scheduler: RTL and testbench

Core-side controller for the SL transceiver's command/response FIFO pair. It pops 34-bit `{modifier, data}` command words written by the APB bridge and dispatches them to the configuration, channel, status-clear and transmit paths. It also arbitrates three requesters into the response FIFO: received data, status changes, and config/channel echoes. The bridge mirrors its register model from these responses.

---
 rtl/sl_fifo_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_sl_fifo_scheduler.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sl_fifo_scheduler.sv
// Command/response FIFO controller for the SL transceiver: dispatches popped command words
// and round-robin arbitrates rx data, status changes and register echoes into the response FIFO.
module sl_fifo_scheduler #(
    parameter int unsigned CONFIG_REG_WIDTH  = 16,
    parameter int unsigned STATUS_REG_WIDTH  = 16,
    parameter int unsigned CHANNEL_REG_WIDTH = 2
) (
    input  logic                         pclk,
    input  logic                         preset_n,
    input  logic                         cmd_fifo_empty,
    input  logic [33:0]                  cmd_fifo_rdata,
    output logic                         cmd_fifo_inc,
    input  logic                         rsp_fifo_full,
    output logic [33:0]                  rsp_fifo_wdata,
    output logic                         rsp_fifo_inc,
    output logic [CONFIG_REG_WIDTH-1:0]  config_out,
    output logic [CHANNEL_REG_WIDTH-1:0] channel_out,
    output logic [STATUS_REG_WIDTH-1:0]  status_out,
    input  logic [STATUS_REG_WIDTH-1:0]  status_set,
    output logic                         tx_valid,
    output logic [31:0]                  tx_data,
    input  logic                         tx_ready,
    input  logic                         rx_valid,
    input  logic [31:0]                  rx_data,
    output logic                         rx_ready
);

    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] MOD_CONFIG  = 2'd0;
    localparam logic [1:0] MOD_DATA    = 2'd1;
    localparam logic [1:0] MOD_STATUS  = 2'd2;
    localparam logic [1:0] MOD_CHANNEL = 2'd3;

    localparam logic [1:0] REQ_RX     = 2'd0;
    localparam logic [1:0] REQ_STATUS = 2'd1;
    localparam logic [1:0] REQ_ECHO   = 2'd2;

    typedef struct packed {
        logic [1:0]        modifier;
        logic [DATA_W-1:0] data;
    } word_t;

    typedef enum logic [1:0] {C_IDLE, C_EXEC, C_TX} cstate_t;

    cstate_t                     state, state_nxt;
    word_t                       cmd_r;
    word_t                       rsp_word_c;
    logic                        echo_pend;
    logic [1:0]                  echo_sel;
    logic [STATUS_REG_WIDTH-1:0] status_r;
    logic                        status_dirty;
    logic [DATA_W-1:0]           rx_hold;
    logic                        rx_hold_v;
    logic [1:0]                  rr_ptr;

    logic       pop_c, exec_c, tx_done_c;
    logic       exec_cfg_c, exec_chn_c, exec_sts_c, exec_dat_c;
    logic [3:0] req_c;
    logic [1:0] p1_c, p2_c, gnt_idx_c;
    logic       gnt_v_c, gnt_rx_c, gnt_sts_c, gnt_echo_c;
    logic       new_bits_c;

    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // State register
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) state <= C_IDLE;
        else           state <= state_nxt;
    end

    // Next-state logic; pops are held off while an echo is still waiting
    always_comb begin
        state_nxt = state;
        case (state)
            C_IDLE:  if (!cmd_fifo_empty && !echo_pend) state_nxt = C_EXEC;
            C_EXEC:  state_nxt = (cmd_r.modifier == MOD_DATA) ? C_TX : C_IDLE;
            C_TX:    if (tx_valid && tx_ready) state_nxt = C_IDLE;
            default: state_nxt = C_IDLE;
        endcase
    end

    // Output decode of the command FSM
    always_comb begin
        pop_c     = 1'b0;
        exec_c    = 1'b0;
        tx_done_c = 1'b0;
        case (state)
            C_IDLE:  pop_c     = !cmd_fifo_empty && !echo_pend;
            C_EXEC:  exec_c    = 1'b1;
            C_TX:    tx_done_c = tx_valid && tx_ready;
            default: ;
        endcase
    end

    assign exec_cfg_c = exec_c && (cmd_r.modifier == MOD_CONFIG);
    assign exec_chn_c = exec_c && (cmd_r.modifier == MOD_CHANNEL);
    assign exec_sts_c = exec_c && (cmd_r.modifier == MOD_STATUS);
    assign exec_dat_c = exec_c && (cmd_r.modifier == MOD_DATA);

    // Round-robin grant starting at rr_ptr; blocked the cycle after a push
    assign req_c = {1'b0, echo_pend, status_dirty, rx_hold_v};
    always_comb begin
        gnt_v_c   = 1'b0;
        gnt_idx_c = rr_ptr;
        p1_c      = rr_next(rr_ptr);
        p2_c      = rr_next(p1_c);
        if (!rsp_fifo_full && !rsp_fifo_inc) begin
            if (req_c[rr_ptr]) begin
                gnt_v_c   = 1'b1;
                gnt_idx_c = rr_ptr;
            end else if (req_c[p1_c]) begin
                gnt_v_c   = 1'b1;
                gnt_idx_c = p1_c;
            end else if (req_c[p2_c]) begin
                gnt_v_c   = 1'b1;
                gnt_idx_c = p2_c;
            end
        end
    end

    assign gnt_rx_c   = gnt_v_c && (gnt_idx_c == REQ_RX);
    assign gnt_sts_c  = gnt_v_c && (gnt_idx_c == REQ_STATUS);
    assign gnt_echo_c = gnt_v_c && (gnt_idx_c == REQ_ECHO);

    always_comb begin
        rsp_word_c = '0;
        case (gnt_idx_c)
            REQ_RX: begin
                rsp_word_c.modifier = MOD_DATA;
                rsp_word_c.data     = rx_hold;
            end
            REQ_STATUS: begin
                rsp_word_c.modifier = MOD_STATUS;
                rsp_word_c.data     = DATA_W'(status_r);
            end
            REQ_ECHO: begin
                rsp_word_c.modifier = echo_sel;
                rsp_word_c.data     = (echo_sel == MOD_CONFIG) ? DATA_W'(config_out)
                                                               : DATA_W'(channel_out);
            end
            default: ;
        endcase
    end

    assign new_bits_c = |(status_set & ~status_r);
    assign status_out = status_r;
    assign rx_ready   = !rx_hold_v;

    // Datapath and registered outputs
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            cmd_fifo_inc   <= 1'b0;
            cmd_r          <= '0;
            config_out     <= '0;
            channel_out    <= '0;
            echo_pend      <= 1'b0;
            echo_sel       <= MOD_CONFIG;
            tx_valid       <= 1'b0;
            tx_data        <= '0;
            status_r       <= '0;
            status_dirty   <= 1'b0;
            rx_hold        <= '0;
            rx_hold_v      <= 1'b0;
            rsp_fifo_inc   <= 1'b0;
            rsp_fifo_wdata <= '0;
            rr_ptr         <= 2'd0;
        end else begin
            cmd_fifo_inc <= pop_c;
            if (pop_c) cmd_r <= cmd_fifo_rdata;

            if (exec_cfg_c) config_out  <= cmd_r.data[CONFIG_REG_WIDTH-1:0];
            if (exec_chn_c) channel_out <= cmd_r.data[CHANNEL_REG_WIDTH-1:0];

            if (exec_cfg_c || exec_chn_c) begin
                echo_pend <= 1'b1;
                echo_sel  <= cmd_r.modifier;
            end else if (gnt_echo_c) begin
                echo_pend <= 1'b0;
            end

            if (exec_dat_c) begin
                tx_data  <= cmd_r.data;
                tx_valid <= 1'b1;
            end else if (tx_done_c) begin
                tx_valid <= 1'b0;
            end

            // Set pulses are OR-ed after the clear so they win on the same bit
            if (exec_sts_c) status_r <= (status_r & ~cmd_r.data[STATUS_REG_WIDTH-1:0]) | status_set;
            else            status_r <= status_r | status_set;

            if (new_bits_c)     status_dirty <= 1'b1;
            else if (gnt_sts_c) status_dirty <= 1'b0;

            if (rx_valid && !rx_hold_v) begin
                rx_hold   <= rx_data;
                rx_hold_v <= 1'b1;
            end else if (gnt_rx_c) begin
                rx_hold_v <= 1'b0;
            end

            rsp_fifo_inc   <= gnt_v_c;
            rsp_fifo_wdata <= gnt_v_c ? rsp_word_c : '0;
            if (gnt_v_c) rr_ptr <= rr_next(gnt_idx_c);
        end
    end

endmodule

// File: tb/tb_sl_fifo_scheduler.sv
// Bench for sl_fifo_scheduler: directed command/response scenarios checked against a
// cycle-level behavioural model plus hand-computed expectations.
module tb_sl_fifo_scheduler;

    logic        pclk = 1'b0;
    logic        preset_n = 1'b1;
    logic        cmd_fifo_empty = 1'b1;
    logic [33:0] cmd_fifo_rdata = '0;
    logic        cmd_fifo_inc;
    logic        rsp_fifo_full = 1'b0;
    logic [33:0] rsp_fifo_wdata;
    logic        rsp_fifo_inc;
    logic [15:0] config_out;
    logic [1:0]  channel_out;
    logic [15:0] status_out;
    logic [15:0] status_set = '0;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic        tx_ready = 1'b0;
    logic        rx_valid = 1'b0;
    logic [31:0] rx_data = '0;
    logic        rx_ready;

    sl_fifo_scheduler #(
        .CONFIG_REG_WIDTH (16),
        .STATUS_REG_WIDTH (16),
        .CHANNEL_REG_WIDTH(2)
    ) dut (
        .pclk          (pclk),
        .preset_n      (preset_n),
        .cmd_fifo_empty(cmd_fifo_empty),
        .cmd_fifo_rdata(cmd_fifo_rdata),
        .cmd_fifo_inc  (cmd_fifo_inc),
        .rsp_fifo_full (rsp_fifo_full),
        .rsp_fifo_wdata(rsp_fifo_wdata),
        .rsp_fifo_inc  (rsp_fifo_inc),
        .config_out    (config_out),
        .channel_out   (channel_out),
        .status_out    (status_out),
        .status_set    (status_set),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .rx_ready      (rx_ready)
    );

    always #5 pclk = ~pclk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int base;
    logic [33:0] cmd_q[$];
    logic [33:0] push_w[$];
    int          push_c[$];
    int          pop_c[$];

    task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [33:0] pw(input int i);
        if (i < push_w.size()) return push_w[i];
        return '1;
    endfunction

    function automatic int pc(input int i);
        if (i < push_c.size()) return push_c[i];
        return -1000;
    endfunction

    function automatic int po(input int i);
        if (i < pop_c.size()) return pop_c[i];
        return -1000;
    endfunction

    // FWFT command FIFO front
    task automatic refresh_fifo();
        if (cmd_q.size() == 0) begin
            cmd_fifo_empty = 1'b1;
            cmd_fifo_rdata = '0;
        end else begin
            cmd_fifo_empty = 1'b0;
            cmd_fifo_rdata = cmd_q[0];
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        if (preset_n && cmd_fifo_inc && cmd_q.size() != 0) void'(cmd_q.pop_front());
        #1;
        cyc++;
        refresh_fifo();
        if (rsp_fifo_inc) begin
            push_w.push_back(rsp_fifo_wdata);
            push_c.push_back(cyc);
        end
        if (cmd_fifo_inc) pop_c.push_back(cyc);
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic push_cmd(input logic [33:0] w);
        cmd_q.push_back(w);
        refresh_fifo();
    endtask

    task automatic clear_logs();
        push_w.delete();
        push_c.delete();
        pop_c.delete();
    endtask

    task automatic do_reset();
        preset_n      = 1'b0;
        cmd_q.delete();
        refresh_fifo();
        rsp_fifo_full = 1'b0;
        status_set    = '0;
        rx_valid      = 1'b0;
        tx_ready      = 1'b0;
        run(2);
        preset_n = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cmd_inc"}, 34'(cmd_fifo_inc), 34'd0);
        chk({tag, "_rsp_inc"}, 34'(rsp_fifo_inc), 34'd0);
        chk({tag, "_rsp_wdata"}, rsp_fifo_wdata, 34'd0);
        chk({tag, "_config"}, 34'(config_out), 34'd0);
        chk({tag, "_channel"}, 34'(channel_out), 34'd0);
        chk({tag, "_status"}, 34'(status_out), 34'd0);
        chk({tag, "_tx_valid"}, 34'(tx_valid), 34'd0);
        chk({tag, "_tx_data"}, 34'(tx_data), 34'd0);
        chk({tag, "_rx_ready"}, 34'(rx_ready), 34'd1);
    endtask

    // Behavioural model: pending requesters, register mirror and a three-phase command slot
    int          m_slot, m_rr, g, ns;
    bit          m_inc, m_rsp_inc, m_dirty, m_rx_v, m_echo, m_tx_v, ninc, was_exec;
    logic [33:0] m_rsp_w, gw;
    logic [15:0] m_cfg, m_st, nb, clr;
    logic [1:0]  m_chn, m_esel, op;
    logic [31:0] m_rx_d, m_tx_d;
    bit          p_rstn = 1'b0, p_full, p_empty, p_tx_ready, p_rx_valid;
    logic [33:0] p_rdata;
    logic [15:0] p_set;
    logic [31:0] p_rx_data;

    function automatic bit req_m(input int c);
        return (c == 0) ? m_rx_v : (c == 1) ? m_dirty : m_echo;
    endfunction

    always @(negedge pclk) begin
        if (!preset_n) begin
            m_slot = 0; m_rr = 0; m_inc = 0; m_rsp_inc = 0; m_rsp_w = '0;
            m_cfg = '0; m_chn = '0; m_st = '0; m_dirty = 0; m_rx_v = 0; m_rx_d = '0;
            m_echo = 0; m_esel = '0; m_tx_v = 0; m_tx_d = '0;
        end else if (p_rstn) begin
            g = -1;
            if (!p_full && !m_rsp_inc)
                for (int k = 0; k < 3; k++)
                    if (g < 0 && req_m((m_rr + k) % 3)) g = (m_rr + k) % 3;
            gw = '0;
            case (g)
                0: gw = {2'd1, m_rx_d};
                1: gw = {2'd2, 16'h0, m_st};
                2: gw = (m_esel == 2'd0) ? {2'd0, 16'h0, m_cfg} : {2'd3, 30'h0, m_chn};
                default: ;
            endcase
            op       = p_rdata[33:32];
            was_exec = (m_slot == 1);
            ninc     = 0;
            ns       = m_slot;
            if (m_slot == 0 && !p_empty && !m_echo) begin
                ns = 1; ninc = 1;
            end else if (m_slot == 1) begin
                ns = (op == 2'd1) ? 2 : 0;
            end else if (m_slot == 2 && p_tx_ready) begin
                ns = 0;
            end
            if (was_exec && op == 2'd1) begin
                m_tx_v = 1; m_tx_d = p_rdata[31:0];
            end else if (m_slot == 2 && p_tx_ready) begin
                m_tx_v = 0;
            end
            if (g == 2) m_echo = 0;
            if (was_exec && op == 2'd0) begin m_cfg = p_rdata[15:0]; m_echo = 1; m_esel = 2'd0; end
            if (was_exec && op == 2'd3) begin m_chn = p_rdata[1:0];  m_echo = 1; m_esel = 2'd3; end
            clr  = (was_exec && op == 2'd2) ? p_rdata[15:0] : 16'h0;
            nb   = p_set & ~m_st;
            m_st = (m_st & ~clr) | p_set;
            if (nb != 0) m_dirty = 1;
            else if (g == 1) m_dirty = 0;
            if (g == 0) m_rx_v = 0;
            else if (p_rx_valid && !m_rx_v) begin m_rx_v = 1; m_rx_d = p_rx_data; end
            m_rsp_inc = (g >= 0);
            m_rsp_w   = gw;
            if (g >= 0) m_rr = (g + 1) % 3;
            m_inc  = ninc;
            m_slot = ns;
        end
        chk("mdl_cmd_inc", 34'(cmd_fifo_inc), 34'(m_inc));
        chk("mdl_rsp_inc", 34'(rsp_fifo_inc), 34'(m_rsp_inc));
        chk("mdl_rsp_wdata", rsp_fifo_wdata, m_rsp_w);
        chk("mdl_config", 34'(config_out), 34'(m_cfg));
        chk("mdl_channel", 34'(channel_out), 34'(m_chn));
        chk("mdl_status", 34'(status_out), 34'(m_st));
        chk("mdl_tx_valid", 34'(tx_valid), 34'(m_tx_v));
        chk("mdl_tx_data", 34'(tx_data), 34'(m_tx_d));
        chk("mdl_rx_ready", 34'(rx_ready), 34'(!m_rx_v));
        p_rstn     = preset_n;
        p_full     = rsp_fifo_full;
        p_empty    = cmd_fifo_empty;
        p_rdata    = cmd_fifo_rdata;
        p_set      = status_set;
        p_tx_ready = tx_ready;
        p_rx_valid = rx_valid;
        p_rx_data  = rx_data;
    end

    initial begin
        #1 preset_n = 1'b0;
        #2 chk_reset_outputs("reset");
        run(2);
        preset_n = 1'b1;
        run(2);

        // CONFIG A5: pop at N+1, config at N+2, echo at N+3
        clear_logs();
        base = cyc;
        push_cmd({2'd0, 32'h0000_00A5});
        tick();
        chk("cfg_pop_n1", 34'(cmd_fifo_inc), 34'd1);
        tick();
        chk("cfg_value_n2", 34'(config_out), 34'h00A5);
        chk("cfg_pop_pulse_end", 34'(cmd_fifo_inc), 34'd0);
        run(6);
        chk("cfg_push_count", 34'(push_w.size()), 34'd1);
        chk("cfg_echo_word", pw(0), {2'd0, 32'h0000_00A5});
        chk("cfg_echo_cycle", 34'(pc(0) - base), 34'd3);

        // DATA with tx_ready low for 5 cycles, CONFIG queued behind it
        clear_logs();
        tx_ready = 1'b0;
        base = cyc;
        push_cmd({2'd1, 32'hDEAD_BEEF});
        push_cmd({2'd0, 32'h0000_1234});
        run(2);
        for (int i = 0; i < 5; i++) begin
            chk("tx_hold_valid", 34'(tx_valid), 34'd1);
            chk("tx_hold_data", 34'(tx_data), 34'(32'hDEAD_BEEF));
            tick();
        end
        chk("tx_no_second_pop", 34'(pop_c.size()), 34'd1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        chk("tx_drop_valid", 34'(tx_valid), 34'd0);
        run(6);
        chk("tx_second_pop_cycle", 34'(po(1) - base), 34'd9);
        chk("tx_next_config", 34'(config_out), 34'h1234);
        chk("tx_echo_word", pw(0), {2'd0, 32'h0000_1234});

        // Status set pulse, then clears without and with a same-cycle set
        clear_logs();
        status_set = 16'h0011;
        tick();
        status_set = 16'h0000;
        run(3);
        chk("sts_value", 34'(status_out), 34'h0011);
        chk("sts_push_word", pw(0), {2'd2, 32'h0000_0011});
        clear_logs();
        push_cmd({2'd2, 32'h0000_0001});
        run(4);
        chk("sts_clear_value", 34'(status_out), 34'h0010);
        chk("sts_clear_no_push", 34'(push_w.size()), 34'd0);
        clear_logs();
        push_cmd({2'd2, 32'h0000_0001});
        tick();
        status_set = 16'h0001;
        tick();
        status_set = 16'h0000;
        chk("sts_set_wins", 34'(status_out), 34'h0011);
        run(4);
        chk("sts_reset_bit_push", pw(0), {2'd2, 32'h0000_0011});

        // All three requesters pending behind a full response FIFO
        do_reset();
        clear_logs();
        rsp_fifo_full = 1'b1;
        rx_valid      = 1'b1;
        rx_data       = 32'h1234_5678;
        status_set    = 16'h0100;
        push_cmd({2'd0, 32'h0000_BEEF});
        tick();
        rx_valid   = 1'b0;
        status_set = 16'h0000;
        run(8);
        chk("full_no_push", 34'(push_w.size()), 34'd0);
        chk("full_rx_held", 34'(rx_ready), 34'd0);
        rsp_fifo_full = 1'b0;
        base = cyc;
        run(10);
        chk("full_push_count", 34'(push_w.size()), 34'd3);
        chk("full_rx_word", pw(0), {2'd1, 32'h1234_5678});
        chk("full_status_word", pw(1), {2'd2, 32'h0000_0100});
        chk("full_echo_word", pw(2), {2'd0, 32'h0000_BEEF});
        chk("full_rx_cycle", 34'(pc(0) - base), 34'd1);
        chk("full_status_cycle", 34'(pc(1) - base), 34'd3);
        chk("full_echo_cycle", 34'(pc(2) - base), 34'd5);

        // Back-to-back CHANNEL commands
        clear_logs();
        base = cyc;
        push_cmd({2'd3, 32'h0000_0001});
        push_cmd({2'd3, 32'h0000_0002});
        run(12);
        chk("chn_echo1", pw(0), {2'd3, 32'h0000_0001});
        chk("chn_echo2", pw(1), {2'd3, 32'h0000_0002});
        chk("chn_second_pop_cycle", 34'(po(1) - base), 34'd4);
        chk("chn_value", 34'(channel_out), 34'd2);

        // Asynchronous reset while a transmit word is waiting
        clear_logs();
        tx_ready = 1'b0;
        push_cmd({2'd1, 32'hCAFE_F00D});
        run(3);
        chk("rst_tx_pending", 34'(tx_valid), 34'd1);
        #2 preset_n = 1'b0;
        cmd_q.delete();
        refresh_fifo();
        #1 chk_reset_outputs("async_reset");
        run(2);
        preset_n = 1'b1;
        clear_logs();
        run(8);
        chk("rst_no_pop", 34'(pop_c.size()), 34'd0);
        chk("rst_no_push", 34'(push_w.size()), 34'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish, got running expected finished");
        $fatal(1);
    end

endmodule
